// File: rtl/cnn_pio_in_multi_if.sv
// Avalon-MM slave bus for cnn_pio_in_multi: register access plus the level interrupt.
interface cnn_pio_in_multi_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/cnn_pio_in_multi.sv
// Multi-channel Avalon-MM input PIO: per-bit synchronisers, registered reads and, when
// CNN_PIO_IN_EDGE_IRQ_EN is defined, rising-edge capture (W1C), IRQ masking and a registered irq.
module cnn_pio_in_multi #(
    parameter int  DATA_W      = 32,
    parameter int  NUM_CH      = 2,
    parameter int  SYNC_STAGES = 2,
    localparam int ADDR_W      = (NUM_CH > 1) ? $clog2(NUM_CH) + 2 : 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    cnn_pio_in_multi_if.slave        bus
);
    localparam int IN_W = NUM_CH * DATA_W;

    logic [SYNC_STAGES-1:0][IN_W-1:0] r_sync;
    logic [IN_W-1:0]                  w_sync;
    logic [ADDR_W-1:0]                w_addr;
    logic [ADDR_W-1:0]                w_ch;
    logic [1:0]                       w_off;
    logic                             w_wr;
    logic [31:0]                      w_rdata;
    logic [31:0]                      r_rdata;
    logic                             w_unused_ok;

    assign w_addr      = bus.address;
    assign w_ch        = w_addr >> 2;
    assign w_off       = w_addr[1:0];
    assign w_wr        = bus.chipselect && !bus.write_n;
    assign w_unused_ok = ^{bus.writedata, w_wr};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef CNN_PIO_IN_EDGE_IRQ_EN
    logic [IN_W-1:0]                  r_prev;
    logic [IN_W-1:0]                  w_edge;
    logic [NUM_CH-1:0][DATA_W-1:0]    r_mask;
    logic [NUM_CH-1:0][DATA_W-1:0]    r_cap;
    logic [NUM_CH-1:0][DATA_W-1:0]    w_clr;
    logic [NUM_CH-1:0]                w_mask_we;
    logic                             w_pend;
    logic                             r_irq;

    assign w_edge = w_sync & ~r_prev;

    // Out-of-range channel indices never match a c, so their writes drop out here.
    always_comb begin
        w_clr     = '0;
        w_mask_we = '0;
        w_pend    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr && w_ch == ADDR_W'(c) && w_off == 2'd3) w_clr[c] = bus.writedata[DATA_W-1:0];
            w_mask_we[c] = w_wr && w_ch == ADDR_W'(c) && w_off == 2'd2;
            w_pend       = w_pend | (|(r_cap[c] & r_mask[c]));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_prev <= '0;
            r_mask <= '0;
            r_cap  <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= w_sync;
            r_irq  <= w_pend;
            for (int c = 0; c < NUM_CH; c++) begin
                // Edge is OR-ed after the clear so a same-cycle edge survives.
                r_cap[c] <= (r_cap[c] & ~w_clr[c]) | w_edge[c*DATA_W +: DATA_W];
                if (w_mask_we[c]) r_mask[c] <= bus.writedata[DATA_W-1:0];
            end
        end
    end

    assign bus.irq = r_irq;
`else
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch == ADDR_W'(c)) begin
                case (w_off)
                    2'd0:    w_rdata[DATA_W-1:0] = w_sync[c*DATA_W +: DATA_W];
`ifdef CNN_PIO_IN_EDGE_IRQ_EN
                    2'd2:    w_rdata[DATA_W-1:0] = r_mask[c];
                    2'd3:    w_rdata[DATA_W-1:0] = r_cap[c];
`endif
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_rdata <= '0;
        else          r_rdata <= w_rdata;
    end

    assign bus.readdata = r_rdata;
endmodule

// File: tb/tb_cnn_pio_in_multi.sv
// Self-checking bench for cnn_pio_in_multi (DATA_W=8, NUM_CH=3, SYNC_STAGES=2) with a
// cycle-level reference model derived from the register map and timing rules.
`timescale 1ns/1ps
module tb_cnn_pio_in_multi;
    localparam int DW  = 8;
    localparam int NCH = 3;
    localparam int S   = 2;
    localparam int AW  = 4;
    localparam int IW  = NCH * DW;
`ifdef CNN_PIO_IN_EDGE_IRQ_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic [IW-1:0] in_port = '0;
    int            n_chk   = 0;
    int            n_fail  = 0;

    cnn_pio_in_multi_if #(.ADDR_W(AW)) bus();

    cnn_pio_in_multi #(.DATA_W(DW), .NUM_CH(NCH), .SYNC_STAGES(S)) dut (
        .clk(clk), .reset_n(reset_n), .in_port(in_port), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: q holds recent in_port samples (q[0] newest); the synchronised
    // value is the sample taken S edges earlier.
    logic [IW-1:0] q[$];
    logic [IW-1:0] m_prev;
    logic [DW-1:0] m_mask[NCH];
    logic [DW-1:0] m_cap[NCH];
    logic [31:0]   m_rd;
    logic          m_irq;

    function automatic logic [31:0] model_read(logic [AW-1:0] a, logic [IW-1:0] sync);
        int ch;
        int off;
        ch  = int'(a[AW-1:2]);
        off = int'(a[1:0]);
        if (ch >= NCH) return 32'h0;
        case (off)
            0:       return 32'(sync[ch*DW +: DW]);
            2:       return EDGE_EN ? 32'(m_mask[ch]) : 32'h0;
            3:       return EDGE_EN ? 32'(m_cap[ch]) : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [IW-1:0] sync;
        logic [DW-1:0] rise;
        logic          pend;
        bit            wr;
        int            wch;
        int            woff;
        if (!reset_n) begin
            q.delete();
            for (int i = 0; i < S; i++) q.push_back('0);
            m_prev = '0;
            for (int c = 0; c < NCH; c++) begin
                m_mask[c] = '0;
                m_cap[c]  = '0;
            end
            m_rd  = '0;
            m_irq = 1'b0;
        end else begin
            sync = q[S-1];
            m_rd = model_read(bus.address, sync);
            pend = 1'b0;
            for (int c = 0; c < NCH; c++) pend = pend | (|(m_cap[c] & m_mask[c]));
            m_irq = EDGE_EN && pend;
            wr   = bus.chipselect && !bus.write_n;
            wch  = int'(bus.address[AW-1:2]);
            woff = int'(bus.address[1:0]);
            for (int c = 0; c < NCH; c++) begin
                rise = sync[c*DW +: DW] & ~m_prev[c*DW +: DW];
                if (wr && wch == c && woff == 3) m_cap[c] = m_cap[c] & ~bus.writedata[DW-1:0];
                m_cap[c] = m_cap[c] | rise;
                if (wr && wch == c && woff == 2) m_mask[c] = bus.writedata[DW-1:0];
            end
            m_prev = sync;
            q.push_front(in_port);
            void'(q.pop_back());
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(int ch, int off);
        bus.address = AW'((ch << 2) | off);
    endtask

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic set_wr(int ch, int off, logic [31:0] d);
        set_addr(ch, off);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.writedata  = d;
    endtask

    task automatic do_wr(int ch, int off, logic [31:0] d);
        set_wr(ch, off, d);
        cyc();
        idle();
    endtask

    task automatic test_reset();
        in_port = '1;
        reset_n = 1'b0;
        idle();
        set_addr(0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_chk++;
            if (bus.readdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_rd: got %h want 0", bus.readdata);
            end
            n_chk++;
            if (bus.irq !== 1'b0) begin
                n_fail++; $display("FAIL reset_irq: got %b want 0", bus.irq);
            end
        end
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            set_addr((k / 4) % 2, k % 4);
            cyc();
            n_chk++;
            if (bus.readdata !== m_rd) begin
                n_fail++; $display("FAIL post_reset_rd k=%0d: got %h want %h", k, bus.readdata, m_rd);
            end
            n_chk++;
            if (bus.irq !== 1'b0) begin
                n_fail++; $display("FAIL post_reset_irq k=%0d: got %b want 0", k, bus.irq);
            end
        end
        set_addr(0, 0); cyc();
        n_chk++;
        if (bus.readdata !== 32'hFF) begin
            n_fail++; $display("FAIL reset_data: got %h want %h", bus.readdata, 32'hFF);
        end
        set_addr(1, 3); cyc();
        n_chk++;
        if (bus.readdata !== (EDGE_EN ? 32'hFF : 32'h0)) begin
            n_fail++; $display("FAIL reset_edgecap: got %h want %h", bus.readdata, EDGE_EN ? 32'hFF : 32'h0);
        end
        set_addr(0, 2); cyc();
        n_chk++;
        if (bus.readdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_irqmask: got %h want 0", bus.readdata);
        end
    endtask

    task automatic test_latency();
        in_port = '0;
        repeat (4) cyc();
        do_wr(1, 3, 32'hFF);
        set_addr(1, 0);
        in_port[DW +: DW] = 8'hA5;
        for (int j = 0; j < 3; j++) begin
            cyc();
            n_chk++;
            if (bus.readdata !== ((j >= 2) ? 32'hA5 : 32'h0)) begin
                n_fail++; $display("FAIL latency_data j=%0d: got %h want %h", j, bus.readdata, (j >= 2) ? 32'hA5 : 32'h0);
            end
        end
        set_addr(1, 3); cyc();
        n_chk++;
        if (bus.readdata !== (EDGE_EN ? 32'hA5 : 32'h0)) begin
            n_fail++; $display("FAIL latency_edgecap: got %h want %h", bus.readdata, EDGE_EN ? 32'hA5 : 32'h0);
        end
    endtask

    task automatic test_irq();
        in_port = '0;
        repeat (4) cyc();
        for (int c = 0; c < NCH; c++) do_wr(c, 3, 32'hFF);
        do_wr(0, 2, 32'h1);
        cyc();
        n_chk++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_idle: got %b want 0", bus.irq);
        end
        in_port[0] = 1'b1;
        for (int j = 0; j <= S + 2; j++) begin
            cyc();
            n_chk++;
            if (bus.irq !== (EDGE_EN && j >= S + 1)) begin
                n_fail++; $display("FAIL irq_rise j=%0d: got %b want %b", j, bus.irq, EDGE_EN && j >= S + 1);
            end
        end
        set_wr(0, 3, 32'h1);
        cyc();
        idle();
        n_chk++;
        if (bus.irq !== EDGE_EN) begin
            n_fail++; $display("FAIL irq_hold: got %b want %b", bus.irq, EDGE_EN);
        end
        cyc();
        n_chk++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear: got %b want 0", bus.irq);
        end
    endtask

    task automatic test_collision();
        in_port[3] = 1'b1;
        for (int j = 0; j < S; j++) cyc();
        do_wr(0, 3, 32'h8);
        set_addr(0, 3); cyc();
        n_chk++;
        if (bus.readdata !== (EDGE_EN ? 32'h8 : 32'h0) || bus.readdata !== m_rd) begin
            n_fail++; $display("FAIL set_wins: got %h want %h", bus.readdata, EDGE_EN ? 32'h8 : 32'h0);
        end
        do_wr(0, 3, 32'h8);
        set_addr(0, 3); cyc();
        n_chk++;
        if (bus.readdata !== 32'h0) begin
            n_fail++; $display("FAIL second_clear: got %h want 0", bus.readdata);
        end
    endtask

    task automatic test_range();
        logic [31:0] exp_mask[NCH];
        exp_mask[0] = EDGE_EN ? 32'h1 : 32'h0;
        exp_mask[1] = 32'h0;
        exp_mask[2] = 32'h0;
        do_wr(3, 2, 32'hFFFFFFFF);
        set_addr(3, 0); cyc();
        n_chk++;
        if (bus.readdata !== 32'h0) begin
            n_fail++; $display("FAIL oor_data: got %h want 0", bus.readdata);
        end
        set_addr(3, 2); cyc();
        n_chk++;
        if (bus.readdata !== 32'h0) begin
            n_fail++; $display("FAIL oor_mask: got %h want 0", bus.readdata);
        end
        set_addr(0, 1); cyc();
        n_chk++;
        if (bus.readdata !== 32'h0) begin
            n_fail++; $display("FAIL reserved: got %h want 0", bus.readdata);
        end
        for (int c = 0; c < NCH; c++) begin
            set_addr(c, 2); cyc();
            n_chk++;
            if (bus.readdata !== exp_mask[c]) begin
                n_fail++; $display("FAIL mask_kept ch%0d: got %h want %h", c, bus.readdata, exp_mask[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_wr(2, 2, 32'hFFFFFF5A);
        cyc();
        idle();
        set_addr(2, 2); cyc();
        n_chk++;
        if (bus.readdata !== (EDGE_EN ? 32'h5A : 32'h0)) begin
            n_fail++; $display("FAIL b2b_mask: got %h want %h", bus.readdata, EDGE_EN ? 32'h5A : 32'h0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = IW'($urandom());
            reset_n = ($urandom_range(0, 99) >= 2);
            set_addr($urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) begin
                bus.chipselect = 1'b1;
                bus.write_n    = 1'b0;
                bus.writedata  = $urandom();
            end else begin
                bus.chipselect = $urandom_range(0, 1) == 1;
                bus.write_n    = 1'b1;
                bus.writedata  = $urandom();
            end
            cyc();
            n_chk++;
            if (bus.readdata !== m_rd) begin
                n_fail++; $display("FAIL rand_rd i=%0d: got %h want %h", i, bus.readdata, m_rd);
            end
            n_chk++;
            if (bus.irq !== m_irq) begin
                n_fail++; $display("FAIL rand_irq i=%0d: got %b want %b", i, bus.irq, m_irq);
            end
        end
        reset_n = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        set_addr(0, 0);
        test_reset();
        test_latency();
        test_irq();
        test_collision();
        test_range();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
